// File: rtl/connect4_turn_controller.sv
// -----------------------------------------------------------------------------
// connect4_turn_controller
//
// Game sequencer for the Connect4 board datapath. Player 1 and Player 2 take
// turns, and each turn accepts one column request. Moves into an invalid
// column or a full column are rejected. The block keeps a fill height for each
// column and strobes the board write with the computed row. After each
// placement it samples an external win checker, then declares a win, a draw,
// or hands the turn to the other player.
//
// Optional feature: define TURN_TIMEOUT_EN to build a per-turn timer. When it
// expires the turn is forfeited. When the macro is undefined, turn_timeout is
// tied to 0 and the timer logic is not built.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset, returns to INIT
//   start        in   begin a new game (only in INIT or END)
//   move_req     in   level request from debouncer, rising edge is acted on
//   move_col     in   requested column, sampled on the move_req edge cycle
//   win_detect   in   win checker result for the current board
//   state        out  00 INIT, 01 P1 turn, 10 P2 turn, 11 END
//   place_en     out  one-cycle strobe to write the mover's token
//   place_col    out  column for place_en
//   place_row    out  row for place_en (0 = bottom)
//   move_ack     out  one-cycle pulse, move accepted
//   move_rej     out  one-cycle pulse, move rejected
//   col_full     out  bit c set when column c holds ROWS tokens
//   winner       out  00 none, 01 P1, 10 P2, 11 draw (valid in END)
//   move_count   out  tokens placed this game
//   turn_timeout out  one-cycle pulse, turn forfeited
//
// FSM states
//   state     | meaning
//   S_INIT    | idle after reset, waiting for start
//   S_P1_WAIT | Player 1 to move
//   S_P2_WAIT | Player 2 to move
//   S_PLACE   | token write strobe, height/count update
//   S_CHECK   | sample win checker on the updated board
//   S_END     | game over, outputs held until start/reset
// -----------------------------------------------------------------------------
module connect4_turn_controller #(
  parameter int COLS           = 7,
  parameter int ROWS           = 6,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            move_req,
  input  logic [2:0]      move_col,
  input  logic            win_detect,
  output logic [1:0]      state,
  output logic            place_en,
  output logic [2:0]      place_col,
  output logic [2:0]      place_row,
  output logic            move_ack,
  output logic            move_rej,
  output logic [COLS-1:0] col_full,
  output logic [1:0]      winner,
  output logic [5:0]      move_count,
  output logic            turn_timeout
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_P1_WAIT = 3'd1,
    S_P2_WAIT = 3'd2,
    S_PLACE   = 3'd3,
    S_CHECK   = 3'd4,
    S_END     = 3'd5
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic       req_q;
  logic       mover_q;   // 0 = Player 1, 1 = Player 2
  logic [2:0] col_q;
  logic [2:0] height_q [COLS];
  logic [5:0] count_q;
  logic [1:0] winner_q;
  logic       ack_q;
  logic       rej_q;

  logic       req_edge;
  logic       in_wait;
  logic       wait_mover;
  logic [7:0] full_pad;
  logic       move_ok;
  logic       move_bad;
  logic       timeout_hit;
  logic       clear_game;
  logic       board_full;

  always_comb begin
    col_full = '0;
    for (int c = 0; c < COLS; c++) begin
      col_full[c] = (height_q[c] == 3'(ROWS));
    end
  end

  // Columns past COLS read as full, so one lookup covers both reject causes.
  assign full_pad   = {{(8 - COLS){1'b1}}, col_full};
  assign req_edge   = move_req & ~req_q;
  assign in_wait    = (fsm_q == S_P1_WAIT) || (fsm_q == S_P2_WAIT);
  assign wait_mover = (fsm_q == S_P2_WAIT);
  assign move_ok    = in_wait & req_edge & ~full_pad[move_col];
  assign move_bad   = in_wait & req_edge &  full_pad[move_col];
  assign board_full = (count_q == 6'(COLS * ROWS));

`ifdef TURN_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;

  // A valid move wins over an expiring timer on the same cycle.
  assign timeout_hit = in_wait & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) & ~move_ok;

  // Restarts whenever the FSM leaves its current WAIT state, so every new turn
  // begins at zero; rejected moves do not restart it.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (in_wait && (fsm_d == fsm_q)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    fsm_d      = fsm_q;
    clear_game = 1'b0;
    case (fsm_q)
      S_INIT, S_END: begin
        if (start) begin
          fsm_d      = S_P1_WAIT;
          clear_game = 1'b1;
        end
      end
      S_P1_WAIT, S_P2_WAIT: begin
        if (move_ok) begin
          fsm_d = S_PLACE;
        end else if (timeout_hit) begin
          fsm_d = wait_mover ? S_P1_WAIT : S_P2_WAIT;
        end
      end
      S_PLACE: fsm_d = S_CHECK;
      S_CHECK: begin
        if (win_detect || board_full) begin
          fsm_d = S_END;
        end else begin
          fsm_d = mover_q ? S_P1_WAIT : S_P2_WAIT;
        end
      end
      default: fsm_d = S_INIT;
    endcase
  end

  always_comb begin
    state = 2'b00;
    case (fsm_q)
      S_INIT:           state = 2'b00;
      S_P1_WAIT:        state = 2'b01;
      S_P2_WAIT:        state = 2'b10;
      S_PLACE, S_CHECK: state = {mover_q, ~mover_q};
      S_END:            state = 2'b11;
      default:          state = 2'b00;
    endcase
  end

  assign place_en     = (fsm_q == S_PLACE);
  assign place_col    = col_q;
  assign place_row    = height_q[col_q];
  assign move_ack     = ack_q;
  assign move_rej     = rej_q;
  assign winner       = winner_q;
  assign move_count   = count_q;
  assign turn_timeout = timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= S_INIT;
      req_q    <= 1'b0;
      mover_q  <= 1'b0;
      col_q    <= '0;
      count_q  <= '0;
      winner_q <= 2'b00;
      ack_q    <= 1'b0;
      rej_q    <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        height_q[c] <= '0;
      end
    end else begin
      fsm_q <= fsm_d;
      // Sampled every cycle so edges outside WAIT are consumed, not queued.
      req_q <= move_req;
      ack_q <= move_ok;
      rej_q <= move_bad;

      if (move_ok) begin
        col_q   <= move_col;
        mover_q <= wait_mover;
      end

      if (clear_game) begin
        count_q  <= '0;
        winner_q <= 2'b00;
        for (int c = 0; c < COLS; c++) begin
          height_q[c] <= '0;
        end
      end

      if ((fsm_q == S_PLACE) && (height_q[col_q] != 3'(ROWS))) begin
        height_q[col_q] <= height_q[col_q] + 3'd1;
        count_q         <= count_q + 6'd1;
      end

      if (fsm_q == S_CHECK) begin
        if (win_detect) begin
          winner_q <= mover_q ? 2'b10 : 2'b01;
        end else if (board_full) begin
          winner_q <= 2'b11;
        end
      end
    end
  end

endmodule

// File: tb/tb_connect4_turn_controller.sv
module tb_connect4_turn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       move_req;
  logic [2:0] move_col;
  logic       win_detect;
  logic [1:0] state;
  logic       place_en;
  logic [2:0] place_col;
  logic [2:0] place_row;
  logic       move_ack;
  logic       move_rej;
  logic [6:0] col_full;
  logic [1:0] winner;
  logic [5:0] move_count;
  logic       turn_timeout;

  connect4_turn_controller dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .move_req     (move_req),
    .move_col     (move_col),
    .win_detect   (win_detect),
    .state        (state),
    .place_en     (place_en),
    .place_col    (place_col),
    .place_row    (place_row),
    .move_ack     (move_ack),
    .move_rej     (move_rej),
    .col_full     (col_full),
    .winner       (winner),
    .move_count   (move_count),
    .turn_timeout (turn_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ack;
    logic       rej;
    logic       pen;
    logic [2:0] col;
    logic [2:0] row;
    logic [1:0] st;
  } ev_t;

  ev_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: any ack/rej/place cycle must match the oldest expected event.
  initial begin
    ev_t a;
    ev_t e;
    forever begin
      @(negedge clk);
      if (move_ack || move_rej || place_en) begin
        a.ack = move_ack;
        a.rej = move_rej;
        a.pen = place_en;
        a.col = place_en ? place_col : 3'd0;
        a.row = place_en ? place_row : 3'd0;
        a.st  = state;
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_event: got ack=%0b rej=%0b pen=%0b col=%0d row=%0d st=%0d expected none",
                   a.ack, a.rej, a.pen, a.col, a.row, a.st);
        end else begin
          e = sb_q.pop_front();
          if (a == e) n_pass++;
          else $display("FAIL event: got ack=%0b rej=%0b pen=%0b col=%0d row=%0d st=%0d expected ack=%0b rej=%0b pen=%0b col=%0d row=%0d st=%0d",
                        a.ack, a.rej, a.pen, a.col, a.row, a.st, e.ack, e.rej, e.pen, e.col, e.row, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int col);
    move_col = 3'(col);
    move_req = 1'b1;
    cyc(1);
    move_req = 1'b0;
    cyc(2);
  endtask

  task automatic move_good(input int col, input int row, input int st);
    sb_q.push_back('{ack: 1'b1, rej: 1'b0, pen: 1'b1, col: 3'(col), row: 3'(row), st: 2'(st)});
    do_req(col);
  endtask

  task automatic move_bad(input int col, input int st);
    sb_q.push_back('{ack: 1'b0, rej: 1'b1, pen: 1'b0, col: 3'd0, row: 3'd0, st: 2'(st)});
    do_req(col);
  endtask

  task automatic new_game();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; move_req = 1'b0; move_col = 3'd0; win_detect = 1'b0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_winner", winner, 0);
    chk("rst_count", move_count, 0);
    chk("rst_col_full", col_full, 0);
    chk("rst_place_en", place_en, 0);
    chk("rst_ack_rej", {move_ack, move_rej}, 0);
    chk("rst_timeout", turn_timeout, 0);
    reset = 1'b0;

    new_game();
    chk("start_p1", state, 1);
    move_good(3, 0, 1);
    chk("after_p1", state, 2);
    move_good(3, 1, 2);
    chk("after_p2", state, 1);

    new_game();
    chk("start_in_wait_state", state, 1);
    chk("start_in_wait_count", move_count, 2);

    move_bad(7, 1);
    chk("rej_col7_state", state, 1);

    for (int i = 0; i < 6; i++) move_good(0, i, (i % 2) ? 2 : 1);
    chk("col0_full", col_full, 7'b0000001);
    chk("count_8", move_count, 8);
    move_bad(0, 1);
    chk("rej_full_state", state, 1);
    chk("rej_full_count", move_count, 8);

    // held request: only the first edge counts
    sb_q.push_back('{ack: 1'b1, rej: 1'b0, pen: 1'b1, col: 3'd4, row: 3'd0, st: 2'd1});
    move_col = 3'd4;
    move_req = 1'b1;
    cyc(6);
    move_req = 1'b0;
    cyc(1);
    chk("held_state", state, 2);
    chk("held_count", move_count, 9);

    // reset while in PLACE
    sb_q.push_back('{ack: 1'b1, rej: 1'b0, pen: 1'b1, col: 3'd3, row: 3'd2, st: 2'd2});
    move_col = 3'd3;
    move_req = 1'b1;
    cyc(1);
    move_req = 1'b0;
    chk("mid_place_en", place_en, 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_place_en", place_en, 0);
    chk("mid_rst_count", move_count, 0);
    chk("mid_rst_col_full", col_full, 0);

    // P1 wins with four in column 0
    new_game();
    for (int k = 0; k < 7; k++) begin
      if (k == 6) win_detect = 1'b1;
      move_good((k % 2) ? 1 : 0, k / 2, (k % 2) ? 2 : 1);
    end
    win_detect = 1'b0;
    chk("win_state", state, 3);
    chk("win_winner", winner, 1);
    chk("win_count", move_count, 7);
    do_req(2);
    chk("end_ignore_state", state, 3);
    chk("end_ignore_count", move_count, 7);
    chk("end_ignore_winner", winner, 1);

    // fill the whole board without a win
    new_game();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        move_good(c, r, ((c * 6 + r) % 2) ? 2 : 1);
    chk("draw_state", state, 3);
    chk("draw_winner", winner, 3);
    chk("draw_count", move_count, 42);
    chk("draw_col_full", col_full, 7'h7f);

    new_game();
    chk("restart_state", state, 1);
    chk("restart_count", move_count, 0);
    chk("restart_winner", winner, 0);
    chk("restart_col_full", col_full, 0);

    cyc(2);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
